bitstream_window_buffer: RTL
============================

Name: bitstream_window_buffer

Overview:
- Upstream feeder for the exp-Golomb decode stage.
- Accepts raw 16-bit bitstream words with a valid/ready handshake and keeps them in a 48-bit MSB-aligned shift window.
- Presents the next 16 unread bits, MSB-first, as the decoder's bitstream input.
- Each cycle the decoder consumes 0..16 bits; the buffer tracks fill level and byte alignment for later slice/NAL parsing.

Parameters:
- WORD_W, 16, input word width and window output width.
- WIN_W, 48, internal window width; must equal 3*WORD_W.
- LVL_W, 6, width of the fill-level counter (holds 0..WIN_W).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of window, level and alignment; higher priority than push or consume.
- in_word  input  16  next bitstream word; bit 15 is first in stream order.
- in_valid  input  1  in_word is valid this cycle.
- in_ready  output  1  buffer can accept in_word this cycle.
- win_data  output  16  next 16 unread bits, MSB = oldest bit.
- win_valid  output  1  at least 16 unread bits are held.
- consume_en  input  1  consume request.
- consume_len  input  5  number of bits to consume, 0..16.
- level  output  6  unread bit count, 0..48.
- bit_pos  output  3  total bits consumed since reset/flush, mod 8; 0 = byte aligned.
- err  output  1  sticky illegal-consume flag; cleared only by reset or flush.

Behaviour:
- Reset (async, reset_n low): window=0, level=0, bit_pos=0, err=0. Therefore in_ready=1, win_valid=0, win_data=0.
- Window storage: window[47:48-level] holds unread bits; all bits below are don't-care but are driven to 0.
- Combinational outputs:
  - win_data = window[47:32].
  - win_valid = (level >= 16).
  - in_ready = (level <= 32). Based on current level only; no combinational path from consume_* to in_ready.
- Push: occurs when in_valid && in_ready.
- Consume legality:
  - Legal when consume_en && consume_len <= 16 && consume_len <= level.
  - Illegal requests (len > 16 or len > level) are ignored: no shift, no level change. err is set the next cycle.
  - consume_len=0 with consume_en is legal and a no-op.
- Per-cycle update, in this order:
  - Let c = consume_len if the consume is legal, else 0.
  - r = level - c.
  - window' = window << c.
  - On push, in_word is written to window'[47-r : 32-r]. r <= 32 is guaranteed because a push requires level <= 32.
  - level' = r + (push ? 16 : 0).
  - bit_pos' = (bit_pos + c) mod 8.
- Simultaneous push and consume in the same cycle: both take effect per the update above. Throughput is one word per cycle while the decoder consumes at least 16 bits per cycle.
- Latency: a pushed word is visible on win_data the next cycle, provided it lands in the top 16 bits.
- Boundary conditions:
  - level=48 (full): in_ready=0; in_valid is held off by the upstream handshake.
  - level<16: win_valid=0, and win_data upper bits show partial data padded with 0.
  - The decoder must not consume while win_valid=0 unless len <= level; len <= level is legal (tail of stream).
- flush (synchronous):
  - Next state equals the reset state.
  - A push or consume in the same cycle is discarded.
  - in_ready is still computed from the current level in that cycle; upstream treats a flushed word as lost.
- Reset asserted mid-operation: all state clears immediately, with no partial-word retention.
- Arithmetic widths:
  - level math is 6-bit unsigned; no wrap is possible given the legality rules.
  - bit_pos math is 3-bit and wraps naturally.

Decomposition:
- Shared package h264_bs_pkg holds WORD_W, WIN_W, LVL_W and the MAX_CONSUME=16 constant. The same package is used by the exp-Golomb stage for its consume-length output.
- One natural sub-module: bs_insert_shifter. It is combinational: it takes window, c, r, in_word and push, and returns window'. This isolates the two barrel shifts from the control/level logic in the top.

Test Plan:
- Reset then push 0xA5C3 and 0x0F0F on consecutive cycles, no consume:
  - after cycle 1: level=16, win_data=0xA5C3, win_valid=1;
  - after cycle 2: level=32.
- From level=32 (0xA5C3,0x0F0F), consume 3:
  - level=29, win_data=0x2E18, bit_pos=3;
  - then consume 5: win_data=0xC30F, bit_pos=0.
- Fill to 48 with three pushes:
  - in_ready=0;
  - assert in_valid with 0xFFFF: level stays 48 and the window is unchanged.
- At level=20: push 0x8001 and consume 16 in the same cycle:
  - level=20, and the new word sits directly after the 4 remaining bits;
  - win_data equals the 4 remaining bits followed by 0x800.
- At level=10: request consume 12 → ignored, level=10, err=1. Request consume 17 at level=40 → ignored, err stays 1.
- At level=30, bit_pos=5, err=1: assert flush together with a push → level=0, bit_pos=0, err=0, word discarded. Then drop reset_n mid-stream → all outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/h264_bs_pkg.sv
// rtl/h264_bs_pkg.sv - shared widths and limits for the bitstream window and exp-Golomb stages
package h264_bs_pkg;

  localparam int WORD_W      = 16;
  localparam int WIN_W       = 48;
  localparam int LVL_W       = 6;
  localparam int MAX_CONSUME = 16;
  localparam int CNT_W       = 5;

  typedef logic [LVL_W-1:0] level_t;
  typedef logic [CNT_W-1:0] count_t;

endpackage

// File: rtl/bs_insert_shifter.sv
// rtl/bs_insert_shifter.sv - drops consumed bits and appends a new word behind the remaining ones
module bs_insert_shifter
  import h264_bs_pkg::*;
(
  input  logic [WIN_W-1:0]  window,
  input  count_t            c,
  input  level_t            r,
  input  logic [WORD_W-1:0] in_word,
  input  logic              push,
  output logic [WIN_W-1:0]  window_next
);

  logic [WIN_W-1:0] shifted;
  logic [WIN_W-1:0] placed;

  // Bits below the unread region are kept at zero, so an OR merges the new word cleanly.
  assign shifted     = window << c;
  assign placed      = {in_word, {(WIN_W-WORD_W){1'b0}}} >> r;
  assign window_next = push ? (shifted | placed) : shifted;

endmodule

// File: rtl/bitstream_window_buffer.sv
// rtl/bitstream_window_buffer.sv - 48-bit MSB-aligned bit window feeding the exp-Golomb decoder
module bitstream_window_buffer
  import h264_bs_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic [15:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] win_data,
  output logic        win_valid,
  input  logic        consume_en,
  input  logic [4:0]  consume_len,
  output logic [5:0]  level,
  output logic [2:0]  bit_pos,
  output logic        err
);

  logic [WIN_W-1:0] window;
  logic [WIN_W-1:0] window_next;
  logic             push;
  logic             legal;
  count_t           c;
  level_t           r;

  assign push  = in_valid && in_ready;
  assign legal = consume_en && (consume_len <= CNT_W'(MAX_CONSUME))
               && ({1'b0, consume_len} <= level);
  assign c     = legal ? consume_len : '0;
  assign r     = level - {1'b0, c};

  bs_insert_shifter u_shifter (
    .window      (window),
    .c           (c),
    .r           (r),
    .in_word     (in_word),
    .push        (push),
    .window_next (window_next)
  );

  // in_ready depends only on the registered level so upstream never sees consume timing.
  assign win_data  = window[WIN_W-1 -: WORD_W];
  assign win_valid = (level >= LVL_W'(WORD_W));
  assign in_ready  = (level <= LVL_W'(WIN_W - WORD_W));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      window  <= '0;
      level   <= '0;
      bit_pos <= '0;
      err     <= 1'b0;
    end else if (flush) begin
      window  <= '0;
      level   <= '0;
      bit_pos <= '0;
      err     <= 1'b0;
    end else begin
      window  <= window_next;
      level   <= r + (push ? LVL_W'(WORD_W) : LVL_W'(0));
      bit_pos <= bit_pos + c[2:0];
      if (consume_en && !legal)
        err <= 1'b1;
    end
  end

endmodule
